// File: rtl/hs_window_sched_pkg.sv
// Shared types and helpers for the windowed round-robin handshake scheduler.
package hs_window_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Bits needed to count 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hs_window_sched_if.sv
// Requester/target side signals of the scheduler, bundled for port hookup.
interface hs_window_sched_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned TO_CNT_W = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  ack;
    logic [NUM_REQ-1:0]  to;
    logic                valid;
    logic                ready;
    logic                busy;
    logic [ID_W-1:0]     cur_id;
    logic [TO_CNT_W-1:0] timeout_count;

    modport master (
        input  req, ready,
        output ack, to, valid, busy, cur_id, timeout_count
    );

    modport slave (
        output req, ready,
        input  ack, to, valid, busy, cur_id, timeout_count
    );
endinterface

// File: rtl/hs_window_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          any_req_o,
    output logic [IW-1:0] grant_id_o
);
    int unsigned idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        any_req_o  = |req_i;
        grant_id_o = '0;
        idx        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + (N - 1 - k)) % N;
            if (req_i[idx]) begin
                grant_id_o = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/hs_window_sched.sv
// Round-robin scheduler sharing one valid/ready target, with a bounded
// ready window per transaction and a saturating timeout counter.
module hs_window_sched
    import hs_window_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_WAIT = 10,
    parameter int unsigned TO_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    hs_window_sched_if.master sched_if
);
    localparam int unsigned         ID_W      = $clog2(NUM_REQ);
    localparam int unsigned         WC_W      = cnt_width(MAX_WAIT);
    localparam logic [WC_W-1:0]     WAIT_LAST = WC_W'(MAX_WAIT);
    localparam logic [ID_W-1:0]     LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [TO_CNT_W-1:0] TO_SAT    = '1;

    state_e              state_q,  state_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic [NUM_REQ-1:0]  ack_q,    ack_d;
    logic [NUM_REQ-1:0]  to_q,     to_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WC_W-1:0]     wait_q,   wait_d;
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

    logic                any_req;
    logic [ID_W-1:0]     grant_id;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req_i      (sched_if.req),
        .ptr_i      (rr_ptr_q),
        .any_req_o  (any_req),
        .grant_id_o (grant_id)
    );

    // Next-state logic; the window exit is decided before wait_q increments.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        ack_d    = '0;
        to_d     = '0;
        cur_id_d = cur_id_q;
        rr_ptr_d = rr_ptr_q;
        wait_d   = wait_q;
        to_cnt_d = to_cnt_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (any_req) begin
                    cur_id_d = grant_id;
                    wait_d   = '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (sched_if.ready || (wait_q == WAIT_LAST)) begin
                    if (sched_if.ready) begin
                        ack_d[cur_id_q] = 1'b1;
                    end else begin
                        to_d[cur_id_q] = 1'b1;
                        if (to_cnt_q != TO_SAT) begin
                            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
                        end
                    end
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (cur_id_q == LAST_ID) ? '0 : cur_id_q + ID_W'(1);
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            to_q     <= '0;
            cur_id_q <= '0;
            rr_ptr_q <= '0;
            wait_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            to_q     <= to_d;
            cur_id_q <= cur_id_d;
            rr_ptr_q <= rr_ptr_d;
            wait_q   <= wait_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign sched_if.valid         = valid_q;
    assign sched_if.busy          = busy_q;
    assign sched_if.ack           = ack_q;
    assign sched_if.to            = to_q;
    assign sched_if.cur_id        = cur_id_q;
    assign sched_if.timeout_count = to_cnt_q;
endmodule

// File: tb/tb_hs_window_sched.sv
// Directed scoreboard bench: three builds (default, MAX_WAIT=0, 2-bit counter).
module tb_hs_window_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hs_window_sched_if #(.NUM_REQ(4), .TO_CNT_W(8)) m_if ();
    hs_window_sched_if #(.NUM_REQ(4), .TO_CNT_W(8)) z_if ();
    hs_window_sched_if #(.NUM_REQ(4), .TO_CNT_W(2)) s_if ();

    hs_window_sched #(.NUM_REQ(4), .MAX_WAIT(10), .TO_CNT_W(8)) u_m (
        .clk(clk), .rst(rst), .sched_if(m_if.master));
    hs_window_sched #(.NUM_REQ(4), .MAX_WAIT(0), .TO_CNT_W(8)) u_z (
        .clk(clk), .rst(rst), .sched_if(z_if.master));
    hs_window_sched #(.NUM_REQ(4), .MAX_WAIT(2), .TO_CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .sched_if(s_if.master));

    typedef struct {
        logic [3:0] ack;
        logic [3:0] to;
        int         id;
        int         tc;
        int         vc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   maxw[3]  = '{10, 0, 2};
    int   tcmax[3] = '{255, 255, 3};
    int   m_ptr[3] = '{0, 0, 0};
    int   m_tc[3]  = '{0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int w, input logic [3:0] v);
        case (w)
            0:       m_if.req = v;
            1:       z_if.req = v;
            default: s_if.req = v;
        endcase
    endtask

    task automatic set_ready(input int w, input logic v);
        case (w)
            0:       m_if.ready = v;
            1:       z_if.ready = v;
            default: s_if.ready = v;
        endcase
    endtask

    task automatic sample(input int w, output logic [3:0] a, output logic [3:0] t,
                          output logic v, output logic [1:0] id, output logic [7:0] tc);
        case (w)
            0: begin a = m_if.ack; t = m_if.to; v = m_if.valid; id = m_if.cur_id;
                     tc = m_if.timeout_count; end
            1: begin a = z_if.ack; t = z_if.to; v = z_if.valid; id = z_if.cur_id;
                     tc = z_if.timeout_count; end
            default: begin a = s_if.ack; t = s_if.to; v = s_if.valid; id = s_if.cur_id;
                     tc = 8'(s_if.timeout_count); end
        endcase
    endtask

    // Reference model: round-robin pick plus window outcome, pushed at drive time.
    function automatic void expect_txn(input int w, input logic [3:0] r, input int ready_at);
        exp_t e;
        int   id = -1;
        logic ok;
        for (int k = 0; k < 4; k++) begin
            if (id < 0 && r[(m_ptr[w] + k) % 4]) id = (m_ptr[w] + k) % 4;
        end
        ok    = (ready_at >= 0) && (ready_at <= maxw[w]);
        e.id  = id;
        e.ack = ok ? 4'(1 << id) : 4'd0;
        e.to  = ok ? 4'd0 : 4'(1 << id);
        if (!ok && m_tc[w] < tcmax[w]) m_tc[w]++;
        e.tc  = m_tc[w];
        e.vc  = ok ? ready_at + 1 : maxw[w] + 1;
        m_ptr[w] = (id + 1) % 4;
        exp_q.push_back(e);
    endfunction

    task automatic wait_result(input int w, input int ready_at, input string tag);
        logic [3:0] a, t;
        logic       v;
        logic [1:0] id;
        logic [7:0] tc;
        int         vc  = 0;
        bit         got = 0;
        exp_t       e;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            sample(w, a, t, v, id, tc);
            if ((a | t) != 4'd0) got = 1;
            else if (v) begin
                vc++;
                set_ready(w, (ready_at >= 0) && (vc - 1 >= ready_at));
            end
        end
        set_ready(w, 1'b0);
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_ack"},   32'(a),  32'(e.ack));
            chk({tag, "_to"},    32'(t),  32'(e.to));
            chk({tag, "_id"},    32'(id), 32'(e.id));
            chk({tag, "_tcnt"},  32'(tc), 32'(e.tc));
            chk({tag, "_vcyc"},  32'(vc), 32'(e.vc));
            chk({tag, "_vgap"},  32'(v),  32'd0);
        end
    endtask

    task automatic txn(input int w, input logic [3:0] r, input int ready_at,
                       input bit hold, input string tag);
        set_req(w, r);
        expect_txn(w, r, ready_at);
        wait_result(w, ready_at, tag);
        if (!hold) set_req(w, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0;
            m_tc[i]  = 0;
        end
    endtask

    initial begin
        m_if.req = '0; m_if.ready = 1'b0;
        z_if.req = '0; z_if.ready = 1'b0;
        s_if.req = '0; s_if.ready = 1'b0;
        do_reset();

        chk("rst_valid",  32'(m_if.valid),         32'd0);
        chk("rst_busy",   32'(m_if.busy),          32'd0);
        chk("rst_ack",    32'(m_if.ack),           32'd0);
        chk("rst_to",     32'(m_if.to),            32'd0);
        chk("rst_cur_id", 32'(m_if.cur_id),        32'd0);
        chk("rst_tcnt",   32'(m_if.timeout_count), 32'd0);

        txn(0, 4'b0001, 0,  0, "t1_imm_ready");
        txn(0, 4'b0010, 10, 0, "t2_ready_last");
        txn(0, 4'b0010, 11, 0, "t2_ready_late");

        do_reset();
        for (int i = 0; i < 5; i++) txn(0, 4'b1111, 0, 1, $sformatf("t3_b2b%0d", i));
        set_req(0, 4'd0);

        txn(1, 4'b0100, 1, 0, "t4_mw0");

        // Abort mid-window: valid must fall on rst alone, before any clock edge.
        @(negedge clk);
        set_req(0, 4'b0100);
        repeat (5) @(negedge clk);
        chk("t5_pre_valid", 32'(m_if.valid), 32'd1);
        chk("t5_pre_id",    32'(m_if.cur_id), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(m_if.valid), 32'd0);
        chk("t5_async_busy",  32'(m_if.busy),  32'd0);
        chk("t5_async_ack",   32'(m_if.ack),   32'd0);
        chk("t5_async_to",    32'(m_if.to),    32'd0);
        chk("t5_async_id",    32'(m_if.cur_id), 32'd0);
        set_req(0, 4'd0);
        @(negedge clk);
        chk("t5_hold_ack", 32'(m_if.ack | m_if.to), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0;
            m_tc[i]  = 0;
        end
        txn(0, 4'b1001, 0, 0, "t5_ptr_zero");
        txn(0, 4'b1000, 0, 0, "t5_id3");

        for (int i = 0; i < 4; i++) txn(2, 4'b0001, -1, 0, $sformatf("t6_sat%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
